// File: rtl/bfp_pkg.sv
// -----------------------------------------------------------------------------
// bfp_pkg
// Shared definitions for the block-floating-point shift-amount stream.
//   shw_f   : default signed shift-amount width for a given sample width
//   state_t : frame accumulator state (IDLE = counter 0, ACCUM = mid-frame)
//   shamt_t : internal signed shift amount, wide enough for any legal WIDTH
// -----------------------------------------------------------------------------
package bfp_pkg;

    // Widest shift amount needed: WIDTH=32 -> $clog2(32)+1 = 6 bits.
    localparam int SHW_MAX = 6;

    function automatic int shw_f(input int width);
        return $clog2(width) + 1;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef logic signed [SHW_MAX-1:0] shamt_t;

endpackage

// File: rtl/bfp_shamt_stream_cls_unit.sv
// -----------------------------------------------------------------------------
// cls_unit
// Combinational count-leading-sign: number of consecutive bits directly below
// the MSB that equal the MSB. Result range 0..WIDTH-1.
//   data_i : WIDTH-bit sample
//   cls_o  : leading sign-bit count (excluding the MSB itself)
// -----------------------------------------------------------------------------
module cls_unit #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    cls_o
);

    logic run;

    always_comb begin
        cls_o = '0;
        run   = 1'b1;
        for (int unsigned k = 0; k < WIDTH - 1; k++) begin
            if (run && (data_i[WIDTH-2-k] == data_i[WIDTH-1])) begin
                cls_o = cls_o + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bfp_shamt_stream.sv
// -----------------------------------------------------------------------------
// bfp_shamt_stream
// Streaming normalisation-shift calculator with per-frame block exponent.
// Each accepted sample is passed through unchanged (1-cycle register slice)
// together with its signed normalisation shift min(CLS - GUARD, MAX_LSH).
// The minimum shift over a frame is reported as bexp_o with a one-cycle
// bexp_valid_o pulse; frame-length violations pulse frame_err_o.
//
// Ports
//   clk, rstn          : clock, synchronous active-high reset
//   s_axis_tvalid/tlast: input beat qualifiers, s_axis_tready back to source
//   data_i             : signed input sample
//   m_axis_tvalid/tlast: output beat qualifiers, m_axis_tready from sink
//   data_o             : registered copy of the accepted sample
//   shamt_o            : signed per-sample shift (+ left, - right)
//   bexp_o             : signed block shift of the last completed frame
//   bexp_valid_o       : one-cycle pulse qualifying bexp_o
//   frame_err_o        : one-cycle pulse on a frame-length violation
// -----------------------------------------------------------------------------
module bfp_shamt_stream
    import bfp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int GUARD     = 1,
    parameter int MAX_LSH   = WIDTH - 1 - GUARD,
    parameter int FRAME_LEN = 64,
    parameter int SHW       = shw_f(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic [WIDTH-1:0]      data_i,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [WIDTH-1:0]      data_o,
    output logic signed [SHW-1:0] shamt_o,
    output logic signed [SHW-1:0] bexp_o,
    output logic                  bexp_valid_o,
    output logic                  frame_err_o
);

    localparam int CW  = $clog2(WIDTH);
    localparam int FCW = $clog2(FRAME_LEN);

    // ---------------------------------------------------------------- checks
    if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
        $error("bfp_shamt_stream: WIDTH %0d outside 8..32", WIDTH);
    end
    if (GUARD < 1 || GUARD > 3) begin : g_bad_guard
        $error("bfp_shamt_stream: GUARD %0d outside 1..3", GUARD);
    end
    if (MAX_LSH < 0 || MAX_LSH > WIDTH - 1 - GUARD) begin : g_bad_max_lsh
        $error("bfp_shamt_stream: MAX_LSH %0d outside 0..WIDTH-1-GUARD", MAX_LSH);
    end
    if (FRAME_LEN < 4 || FRAME_LEN > 4096 ||
        (FRAME_LEN & (FRAME_LEN - 1)) != 0) begin : g_bad_frame_len
        $error("bfp_shamt_stream: FRAME_LEN %0d not a power of two in 4..4096", FRAME_LEN);
    end
    if (SHW < shw_f(WIDTH) || SHW > SHW_MAX) begin : g_bad_shw
        $error("bfp_shamt_stream: SHW %0d cannot hold the shift range", SHW);
    end

    // ------------------------------------------------------------- CLS unit
    logic [CW-1:0] cls;

    cls_unit #(
        .WIDTH (WIDTH)
    ) u_cls (
        .data_i (data_i),
        .cls_o  (cls)
    );

    // ------------------------------------------------------- per-sample shift
    shamt_t raw_shift;
    shamt_t smp_shift;

    always_comb begin
        raw_shift = shamt_t'(cls) - shamt_t'(GUARD);
        smp_shift = (raw_shift > shamt_t'(MAX_LSH)) ? shamt_t'(MAX_LSH) : raw_shift;
    end

    // ------------------------------------------------------------ registers
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q,  m_tlast_d;
    logic [WIDTH-1:0]      data_q,     data_d;
    logic signed [SHW-1:0] shamt_q,    shamt_d;
    logic signed [SHW-1:0] bexp_q,     bexp_d;
    logic                  bexp_vld_q, bexp_vld_d;
    logic                  ferr_q,     ferr_d;
    logic [FCW-1:0]        cnt_q,      cnt_d;
    shamt_t                min_q,      min_d;
    state_t                state_q,    state_d;

    // ------------------------------------------------------------ handshake
    logic in_acc;
    logic out_acc;
    logic cnt_last;
    logic frame_end;

    // rstn term keeps the source unblocked during the very first reset cycle,
    // when the output register may still hold a beat; those beats are dropped.
    assign s_axis_tready = rstn || !m_tvalid_q || m_axis_tready;
    assign in_acc        = s_axis_tvalid && s_axis_tready;
    assign out_acc       = m_tvalid_q && m_axis_tready;
    assign cnt_last      = (cnt_q == FCW'(FRAME_LEN - 1));
    assign frame_end     = s_axis_tlast || cnt_last;

    // ---------------------------------------------------------- FSM process
    always_comb begin
        state_d = state_q;
        if (in_acc) begin
            state_d = frame_end ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------- datapath process
    shamt_t base_min;
    shamt_t new_min;

    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        data_d     = data_q;
        shamt_d    = shamt_q;
        bexp_d     = bexp_q;
        bexp_vld_d = 1'b0;
        ferr_d     = 1'b0;
        cnt_d      = cnt_q;
        min_d      = min_q;

        // First beat of a frame folds against MAX_LSH, not a stale minimum.
        base_min = (state_q == IDLE) ? shamt_t'(MAX_LSH) : min_q;
        new_min  = (smp_shift < base_min) ? smp_shift : base_min;

        if (in_acc) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = s_axis_tlast;
            data_d     = data_i;
            shamt_d    = SHW'(smp_shift);
            if (frame_end) begin
                bexp_d     = SHW'(new_min);
                bexp_vld_d = 1'b1;
                // Error when tlast and the length boundary disagree.
                ferr_d     = (s_axis_tlast != cnt_last);
                cnt_d      = '0;
                min_d      = shamt_t'(MAX_LSH);
            end else begin
                cnt_d = cnt_q + FCW'(1);
                min_d = new_min;
            end
        end else if (out_acc) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            data_q     <= '0;
            shamt_q    <= '0;
            bexp_q     <= '0;
            bexp_vld_q <= 1'b0;
            ferr_q     <= 1'b0;
            cnt_q      <= '0;
            min_q      <= shamt_t'(MAX_LSH);
        end else begin
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            data_q     <= data_d;
            shamt_q    <= shamt_d;
            bexp_q     <= bexp_d;
            bexp_vld_q <= bexp_vld_d;
            ferr_q     <= ferr_d;
            cnt_q      <= cnt_d;
            min_q      <= min_d;
        end
    end

    // -------------------------------------------------------------- outputs
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign data_o        = data_q;
    assign shamt_o       = shamt_q;
    assign bexp_o        = bexp_q;
    assign bexp_valid_o  = bexp_vld_q;
    assign frame_err_o   = ferr_q;

endmodule

// File: tb/tb_bfp_shamt_stream.sv
// -----------------------------------------------------------------------------
// tb_bfp_shamt_stream
// Directed bench for bfp_shamt_stream at WIDTH=8, GUARD=1, MAX_LSH=6,
// FRAME_LEN=4. Inputs change on the falling edge, outputs are sampled 1 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_bfp_shamt_stream;

    logic              clk = 1'b0;
    logic              rstn;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic [7:0]        m_data;
    logic signed [3:0] shamt;
    logic signed [3:0] bexp;
    logic              bexp_valid;
    logic              frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bfp_shamt_stream #(
        .WIDTH     (8),
        .GUARD     (1),
        .MAX_LSH   (6),
        .FRAME_LEN (4)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tvalid (s_valid),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .data_i        (s_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .data_o        (m_data),
        .shamt_o       (shamt),
        .bexp_o        (bexp),
        .bexp_valid_o  (bexp_valid),
        .frame_err_o   (frame_err)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn    = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rstn = 1'b0;
    endtask

    logic [7:0] ps_in  [7] = '{8'h01, 8'h7F, 8'h20, 8'h10, 8'h00, 8'h80, 8'hC0};
    int         ps_exp [7] = '{5, -1, 0, 1, 6, -1, 0};

    initial begin
        // ---- reset state, with a beat offered during reset
        rstn    = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_last  = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_shamt", shamt, 0);
        chk("rst_bexp", bexp, 0);
        chk("rst_bexp_valid", bexp_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_s_ready", s_ready, 1);
        @(negedge clk);
        rstn    = 1'b0;
        s_valid = 1'b0;

        // ---- per-sample shift; 4th beat without tlast wraps the frame
        for (int i = 0; i < 7; i++) begin
            beat(ps_in[i], 1'b0);
            chk("ps_valid", m_valid, 1);
            chk("ps_data", m_data, ps_in[i]);
            chk("ps_shamt", shamt, ps_exp[i]);
            if (i == 0) begin
                chk("ps_no_err_first", frame_err, 0);
            end
            if (i == 3) begin
                chk("wrap_frame_err", frame_err, 1);
                chk("wrap_bexp_valid", bexp_valid, 1);
                chk("wrap_bexp", bexp, -1);
            end
            if (i == 4) begin
                chk("wrap_err_one_cycle", frame_err, 0);
            end
        end
        idle();
        chk("drain_valid", m_valid, 0);
        do_reset();

        // ---- well-formed frame
        beat(8'h01, 1'b0);
        chk("blk_bv_1", bexp_valid, 0);
        beat(8'h10, 1'b0);
        chk("blk_bv_2", bexp_valid, 0);
        beat(8'h08, 1'b0);
        chk("blk_bv_3", bexp_valid, 0);
        chk("blk_shamt_3", shamt, 2);
        beat(8'h02, 1'b1);
        chk("blk_bexp", bexp, 1);
        chk("blk_bexp_valid", bexp_valid, 1);
        chk("blk_frame_err", frame_err, 0);
        chk("blk_m_last", m_last, 1);
        idle();
        chk("blk_bv_drop", bexp_valid, 0);
        chk("blk_bexp_hold", bexp, 1);

        // ---- short frame: tlast on 2nd beat, then a full frame after restart
        beat(8'h10, 1'b0);
        beat(8'h20, 1'b1);
        chk("short_frame_err", frame_err, 1);
        chk("short_bexp_valid", bexp_valid, 1);
        chk("short_bexp", bexp, 0);
        beat(8'h00, 1'b0);
        chk("restart_err_clear", frame_err, 0);
        beat(8'h00, 1'b0);
        beat(8'h00, 1'b0);
        chk("restart_bv_3", bexp_valid, 0);
        beat(8'h00, 1'b1);
        chk("restart_bexp", bexp, 6);
        chk("restart_bexp_valid", bexp_valid, 1);
        chk("restart_frame_err", frame_err, 0);
        idle();

        // ---- backpressure: 3 cycles of m_ready=0 with 2 beats offered
        @(negedge clk);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h01;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_a_data", m_data, 8'h01);
        chk("bp_a_valid", m_valid, 1);
        chk("bp_s_ready_0", s_ready, 0);
        @(negedge clk);
        s_data = 8'h10;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_data", m_data, 8'h01);
            chk("bp_hold_shamt", shamt, 5);
            chk("bp_hold_valid", m_valid, 1);
            chk("bp_hold_s_ready", s_ready, 0);
        end
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        chk("bp_release_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        chk("bp_b_data", m_data, 8'h10);
        chk("bp_b_shamt", shamt, 1);
        chk("bp_b_valid", m_valid, 1);
        beat(8'h08, 1'b0);
        chk("bp_c_data", m_data, 8'h08);
        beat(8'h02, 1'b1);
        chk("bp_d_data", m_data, 8'h02);
        chk("bp_frame_bexp", bexp, 1);
        chk("bp_frame_bv", bexp_valid, 1);
        chk("bp_frame_err", frame_err, 0);
        idle();
        chk("bp_drain_valid", m_valid, 0);

        // ---- reset mid-frame, then a full frame of 0x7F
        beat(8'h01, 1'b0);
        beat(8'h10, 1'b0);
        @(negedge clk);
        rstn    = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h7F;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_last", m_last, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_shamt", shamt, 0);
        chk("mid_rst_bexp", bexp, 0);
        chk("mid_rst_bv", bexp_valid, 0);
        chk("mid_rst_err", frame_err, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        @(negedge clk);
        rstn    = 1'b0;
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(8'h7F, 1'b0);
            chk("post_rst_bv", bexp_valid, 0);
            chk("post_rst_err", frame_err, 0);
            chk("post_rst_shamt", shamt, -1);
        end
        beat(8'h7F, 1'b1);
        chk("post_rst_bexp", bexp, -1);
        chk("post_rst_bexp_valid", bexp_valid, 1);
        chk("post_rst_frame_err", frame_err, 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bfp_shamt_stream.md
BFP_SHAMT_STREAM -- requirements
Module: bfp_shamt_stream

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits, legal range 8..32.
REQ-002 Parameter GUARD, default 1, number of redundant sign bits kept after normalisation, legal 1..3.
REQ-003 Parameter MAX_LSH, default WIDTH-1-GUARD, cap on the left shift.
REQ-004 Parameter FRAME_LEN, default 64, samples per frame, power of two, 4..4096.
REQ-005 Parameter SHW, default $clog2(WIDTH)+1, signed shift-amount width.
REQ-006 Clock and reset: clk_rstn_i.clk in, 1 bit, sole clock. clk_rstn_i.rstn in, 1 bit, reset, synchronous and active-high.
REQ-007 s_axis.tvalid, s_axis.tlast in, 1 bit each; s_axis.tready out, 1 bit; input beat handshake.
REQ-008 data_i  in  WIDTH  signed input sample.
REQ-009 m_axis.tvalid, m_axis.tlast out, 1 bit each; m_axis.tready in, 1 bit; output beat handshake.
REQ-010 data_o  out  WIDTH  input sample passed through unchanged.
REQ-011 shamt_o  out  SHW  signed per-sample shift; positive means left, negative means right.
REQ-012 bexp_o  out  SHW  signed block shift for the completed frame.
REQ-013 bexp_valid_o  out  1  one-cycle pulse qualifying bexp_o.
REQ-014 frame_err_o  out  1  one-cycle pulse on a frame-length violation.

Function
REQ-015 CLS(x) is the count of consecutive bits below the MSB that equal the MSB, range 0..WIDTH-1.
REQ-016 Per-sample shift = min(CLS(data_i) - GUARD, MAX_LSH), computed in signed SHW arithmetic; it can never fall below -GUARD.
REQ-017 Zero and all-ones inputs give CLS = WIDTH-1, so they saturate to MAX_LSH.
REQ-018 Input acceptance occurs when s_axis.tvalid && s_axis.tready; output acceptance occurs when m_axis.tvalid && m_axis.tready.
REQ-019 s_axis.tready = !m_axis.tvalid || m_axis.tready, combinational, with no combinational path from data_i to any output.
REQ-020 On input acceptance, data_o, shamt_o, m_axis.tlast and m_axis.tvalid load on the next edge, giving a latency of 1 cycle.
REQ-021 m_axis.tvalid clears on output acceptance without simultaneous input acceptance; while stalled, all m_axis outputs hold stable.
REQ-022 Simultaneous input and output acceptance reloads the register, and m_axis.tvalid stays 1.
REQ-023 The frame counter increments on each input acceptance and returns to 0 on the tlast beat or when it wraps at FRAME_LEN-1.
REQ-024 The running minimum starts at MAX_LSH at frame start and is updated with min(running, per-sample shift) on each accepted beat, including the first.
REQ-025 On an accepted tlast beat, bexp_o takes the final minimum, including that beat, and bexp_valid_o pulses on the next cycle.
REQ-026 bexp_o holds until the next pulse; bexp_valid_o has no backpressure.
REQ-027 frame_err_o pulses in either of two cases:
- tlast is accepted with counter != FRAME_LEN-1;
- the counter reaches FRAME_LEN-1 without tlast.
REQ-028 When frame_err_o pulses, bexp_valid_o still pulses for the truncated or forced frame, and the counter restarts at 0.
REQ-029 States are IDLE (counter 0, minimum reset) and ACCUM (counter > 0).
- IDLE goes to ACCUM on a non-tlast acceptance.
- ACCUM returns to IDLE on tlast or wrap.

Reset
REQ-030 While rstn is 1 at a clock edge, the following clear to 0: m_axis.tvalid, m_axis.tlast, data_o, shamt_o, bexp_o, bexp_valid_o, frame_err_o and the frame counter; the minimum is set to MAX_LSH and the state to IDLE.
REQ-031 A reset mid-frame discards the partial frame, with no bexp_valid_o and no frame_err_o for it.
REQ-032 During reset s_axis.tready is 1, but beats offered in reset cycles are dropped.

Structure
REQ-033 Package bfp_pkg holds the SHW width function, the state enum type and the shift-amount typedef.
REQ-034 Sub-module cls_unit is a combinational, WIDTH-parametrised count-leading-sign unit, instantiated once.
REQ-035 Elaboration fails with $error on illegal WIDTH, GUARD, MAX_LSH or FRAME_LEN values.

Verification (WIDTH=8, GUARD=1, MAX_LSH=6, FRAME_LEN=4)
REQ-036 Per-sample: inputs 0x01, 0x7F, 0x20, 0x10, 0x00, 0x80, 0xC0 give shamt_o 5, -1, 0, 1, 6, -1, 0, each 1 cycle after acceptance.
REQ-037 Block: frame 0x01, 0x10, 0x08, 0x02 with tlast on the 4th beat gives bexp_o = 1, bexp_valid_o pulsing 1 cycle after the 4th beat, and frame_err_o = 0.
REQ-038 Backpressure: hold m_axis.tready = 0 for 3 cycles with 2 beats offered; the first beat holds stable on the outputs, s_axis.tready = 0, and no beat is lost or duplicated after release.
REQ-039 Frame errors:
- tlast on the 2nd beat gives frame_err_o and bexp_valid_o pulses together with the 2-beat minimum.
- 4 beats with no tlast gives frame_err_o at the wrap.
REQ-040 Reset: assert rstn after 2 beats of a frame, then send a full frame of 0x7F; bexp_o = -1, the partial frame produces no pulse, and all outputs are 0 during reset.
